// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared state encoding and widths for the data-memory responder
package mips_mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - MEM-stage request/response bus between pipeline and data memory
interface dmem_responder_if;
  import mips_mem_pkg::*;

  logic              req_valid;
  logic              req_we;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              req_ready;
  logic              resp_valid;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;
  logic              stall;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - 2**ADDR_W x 32 byte-enabled storage, synchronous write, async clear
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BE_W-1:0]   be,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with WAIT_CYCLES wait states and pipeline stall
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam bit         HAS_WAIT = (WAIT_CYCLES > 0);
  localparam logic [3:0] CNT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state;
  logic [3:0]        cnt;
  logic              lat_we;
  logic [WORD_W-1:0] lat_addr;
  logic [WORD_W-1:0] lat_wdata;
  logic [BE_W-1:0]   lat_be;

  logic              resp_valid_q;
  logic [WORD_W-1:0] resp_rdata_q;
  logic              resp_err_q;

  logic              accept;
  logic              commit;
  logic              c_we;
  logic [WORD_W-1:0] c_addr;
  logic [WORD_W-1:0] c_wdata;
  logic [BE_W-1:0]   c_be;
  logic              aligned;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;
  logic              unused_addr_hi;

  assign bus.req_ready  = (state != S_WAIT);
  assign accept         = bus.req_valid && bus.req_ready;
  assign bus.stall      = (state == S_WAIT) || (accept && HAS_WAIT);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  // Without wait states the access commits on the accepting edge, so it uses the live request.
  assign commit  = HAS_WAIT ? (state == S_WAIT && cnt == 4'd0) : accept;
  assign c_we    = HAS_WAIT ? lat_we    : bus.req_we;
  assign c_addr  = HAS_WAIT ? lat_addr  : bus.req_addr;
  assign c_wdata = HAS_WAIT ? lat_wdata : bus.req_wdata;
  assign c_be    = HAS_WAIT ? lat_be    : bus.req_be;

  assign aligned        = is_aligned(c_addr[1:0]);
  assign mem_we         = commit && c_we && aligned;
  assign unused_addr_hi = ^c_addr[WORD_W-1:ADDR_W+2];

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .addr  (c_addr[ADDR_W+1:2]),
    .be    (c_be),
    .wdata (c_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_be       <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= commit;
      resp_err_q   <= commit && !aligned;
      resp_rdata_q <= (commit && !c_we && aligned) ? mem_rdata : '0;

      if (accept) begin
        lat_we    <= bus.req_we;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
        lat_be    <= bus.req_be;
      end

      case (state)
        S_IDLE, S_RESP: begin
          if (accept) begin
            if (HAS_WAIT) begin
              state <= S_WAIT;
              cnt   <= CNT_LOAD;
            end else begin
              state <= S_RESP;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed vector bench for dmem_responder (WAIT_CYCLES 2 and 0)
module tb_dmem_responder;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  dmem_responder_if a2();
  dmem_responder_if a0();

  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(a2.slave));
  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(a0.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[14];
  logic [31:0] b2b_data[3];

  function automatic vec_t mk(input string nm, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.name = nm; v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic drive2(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
    a2.req_valid = 1'b1;
    a2.req_we    = we;
    a2.req_addr  = addr;
    a2.req_wdata = wdata;
    a2.req_be    = be;
  endtask

  // One isolated access on the WAIT_CYCLES=2 instance: response lands on the third cycle after accept.
  task automatic access2(input vec_t v);
    @(negedge clk);
    chk({v.name, ":pulse_end"}, 32'(a2.resp_valid), 32'd0);
    drive2(v.we, v.addr, v.wdata, v.be);
    #1;
    chk({v.name, ":ready"}, 32'(a2.req_ready), 32'd1);
    chk({v.name, ":stall_acc"}, 32'(a2.stall), 32'd1);
    @(negedge clk);
    a2.req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk({v.name, ":stall_wait"}, 32'(a2.stall), 32'd1);
      chk({v.name, ":early_valid"}, 32'(a2.resp_valid), 32'd0);
      @(negedge clk);
    end
    chk({v.name, ":resp_valid"}, 32'(a2.resp_valid), 32'd1);
    chk({v.name, ":rdata"}, a2.resp_rdata, v.exp_rdata);
    chk({v.name, ":err"}, 32'(a2.resp_err), 32'(v.exp_err));
    chk({v.name, ":stall_resp"}, 32'(a2.stall), 32'd0);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    a2.req_valid = 1'b0; a2.req_we = 1'b0; a2.req_addr = '0; a2.req_wdata = '0; a2.req_be = '0;
    a0.req_valid = 1'b0; a0.req_we = 1'b0; a0.req_addr = '0; a0.req_wdata = '0; a0.req_be = '0;

    vecs[0]  = mk("ld_10_reset",    1'b0, 32'h10,  32'h0,        4'hF, 32'h0,        1'b0);
    vecs[1]  = mk("st_20_full",     1'b1, 32'h20,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0);
    vecs[2]  = mk("ld_20_full",     1'b0, 32'h20,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0);
    vecs[3]  = mk("st_20_byte0",    1'b1, 32'h20,  32'h000000AA, 4'h1, 32'h0,        1'b0);
    vecs[4]  = mk("ld_20_byte0",    1'b0, 32'h20,  32'h0,        4'hF, 32'hDEADBEAA, 1'b0);
    vecs[5]  = mk("ld_13_misalign", 1'b0, 32'h13,  32'h0,        4'hF, 32'h0,        1'b1);
    vecs[6]  = mk("st_12_misalign", 1'b1, 32'h12,  32'hFFFFFFFF, 4'hF, 32'h0,        1'b1);
    vecs[7]  = mk("ld_10_unchg",    1'b0, 32'h10,  32'h0,        4'hF, 32'h0,        1'b0);
    vecs[8]  = mk("st_00",          1'b1, 32'h0,   32'hCAFEF00D, 4'hF, 32'h0,        1'b0);
    vecs[9]  = mk("ld_400_alias",   1'b0, 32'h400, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0);
    vecs[10] = mk("st_24_be0",      1'b1, 32'h24,  32'h11111111, 4'h0, 32'h0,        1'b0);
    vecs[11] = mk("ld_24_be0",      1'b0, 32'h24,  32'h0,        4'hF, 32'h0,        1'b0);
    vecs[12] = mk("st_20_be1010",   1'b1, 32'h20,  32'h55667788, 4'hA, 32'h0,        1'b0);
    vecs[13] = mk("ld_20_be1010",   1'b0, 32'h20,  32'h0,        4'hF, 32'h55AD77AA, 1'b0);

    b2b_data[0] = 32'hA0A0A0A0;
    b2b_data[1] = 32'hB1B1B1B1;
    b2b_data[2] = 32'hC2C2C2C2;

    #1;
    chk("rst_valid2", 32'(a2.resp_valid), 32'd0);
    chk("rst_rdata2", a2.resp_rdata, 32'd0);
    chk("rst_err2", 32'(a2.resp_err), 32'd0);
    chk("rst_ready2", 32'(a2.req_ready), 32'd1);
    chk("rst_stall2", 32'(a2.stall), 32'd0);
    chk("rst_valid0", 32'(a0.resp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) access2(vecs[k]);

    // Back-to-back load then store to one word: load sees old data, then store commits.
    access2(mk("st_30_seed", 1'b1, 32'h30, 32'h01020304, 4'hF, 32'h0, 1'b0));
    @(negedge clk);
    drive2(1'b0, 32'h30, 32'h0, 4'hF);
    @(negedge clk);
    a2.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_ld_valid", 32'(a2.resp_valid), 32'd1);
    chk("b2b_ld_old", a2.resp_rdata, 32'h01020304);
    drive2(1'b1, 32'h30, 32'h0A0B0C0D, 4'hF);
    #1;
    chk("b2b_resp_ready", 32'(a2.req_ready), 32'd1);
    chk("b2b_resp_stall", 32'(a2.stall), 32'd1);
    @(negedge clk);
    a2.req_valid = 1'b0;
    chk("b2b_st_wait1", 32'(a2.resp_valid), 32'd0);
    @(negedge clk);
    chk("b2b_st_wait2", 32'(a2.resp_valid), 32'd0);
    @(negedge clk);
    chk("b2b_st_valid", 32'(a2.resp_valid), 32'd1);
    chk("b2b_st_rdata", a2.resp_rdata, 32'd0);
    access2(mk("ld_30_new", 1'b0, 32'h30, 32'h0, 4'hF, 32'h0A0B0C0D, 1'b0));

    // Zero-wait instance: three back-to-back stores, then three back-to-back loads.
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (i > 0) begin
          chk("w0_valid", 32'(a0.resp_valid), 32'd1);
          chk("w0_rdata", a0.resp_rdata, (p == 1) ? b2b_data[i-1] : 32'd0);
          chk("w0_err", 32'(a0.resp_err), 32'd0);
        end
        if (i < 3) begin
          a0.req_valid = 1'b1;
          a0.req_we    = (p == 0);
          a0.req_addr  = 32'(i * 4);
          a0.req_wdata = b2b_data[i];
          a0.req_be    = 4'hF;
        end else begin
          a0.req_valid = 1'b0;
        end
        #1;
        chk("w0_stall", 32'(a0.stall), 32'd0);
        chk("w0_ready", 32'(a0.req_ready), 32'd1);
      end
      @(negedge clk);
      chk("w0_idle", 32'(a0.resp_valid), 32'd0);
    end

    // Reset during the first WAIT cycle of a store drops it and clears memory.
    @(negedge clk);
    drive2(1'b1, 32'h40, 32'h12345678, 4'hF);
    @(negedge clk);
    a2.req_valid = 1'b0;
    chk("rst_pre_stall", 32'(a2.stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_stall", 32'(a2.stall), 32'd0);
    chk("rst_async_ready", 32'(a2.req_ready), 32'd1);
    chk("rst_async_valid", 32'(a2.resp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    access2(mk("ld_40_after_rst", 1'b0, 32'h40, 32'h0, 4'hF, 32'h0, 1'b0));
    access2(mk("ld_30_cleared",   1'b0, 32'h30, 32'h0, 4'hF, 32'h0, 1'b0));
    access2(mk("ld_00_w0_cleared", 1'b0, 32'h0, 32'h0, 4'hF, 32'h0, 1'b0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
